// File: rtl/noc_output_port_arbiter.sv
// Wormhole output-port allocator for one router output.
// Head flits from the input buffers compete round-robin for the link.
// The winner keeps the link until its tail flit passes, so packets never interleave.
// A credit counter tracks free slots in the downstream buffer.
// The selected flit is registered onto the link with one cycle of latency.
module noc_output_port_arbiter #(
    parameter int NUM_PORTS = 5,
    parameter int FLIT_W    = 34,
    parameter int BUF_DEPTH = 4,
    parameter int PTR_W     = $clog2(NUM_PORTS),
    parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        head,
    input  logic [NUM_PORTS-1:0]        tail,
    input  logic [NUM_PORTS*FLIT_W-1:0] in_flit,
    input  logic                        credit_in,
    output logic [NUM_PORTS-1:0]        grant,
    output logic                        out_valid,
    output logic [FLIT_W-1:0]           out_flit,
    output logic                        locked,
    output logic [PTR_W-1:0]            owner,
    output logic [CNT_W-1:0]            credits,
    output logic                        err
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_next;
    logic [PTR_W-1:0]  owner_next;
    logic [PTR_W-1:0]  sel;
    logic [PTR_W-1:0]  winner;
    logic [PTR_W:0]    cand;
    logic              found;
    logic              transfer;
    logic              has_credit;
    logic [CNT_W-1:0]  credits_next;
    logic              err_next;
    logic [FLIT_W-1:0] flit_array [NUM_PORTS];

    // Advances a port index by one, wrapping back to port 0 after the last port.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NUM_PORTS - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Unpacks the flattened flit bus so the selected flit can be picked by index.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign flit_array[g] = in_flit[g*FLIT_W +: FLIT_W];
    end

    assign locked = (state == LOCKED);

    // Picks the input to serve this cycle, computes next FSM/pointer/credit/error values.
    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        owner_next   = owner;
        sel          = owner;
        winner       = '0;
        cand         = '0;
        found        = 1'b0;
        transfer     = 1'b0;
        err_next     = err;
        credits_next = credits;
        grant        = '0;
        has_credit   = (credits != '0);

        case (state)
            IDLE: begin
                if (|(req & ~head)) begin
                    err_next = 1'b1;
                end
                for (int i = 0; i < NUM_PORTS; i++) begin
                    cand = {1'b0, ptr} + (PTR_W+1)'(i);
                    if (cand >= (PTR_W+1)'(NUM_PORTS)) begin
                        cand = cand - (PTR_W+1)'(NUM_PORTS);
                    end
                    if (!found && req[cand[PTR_W-1:0]] && head[cand[PTR_W-1:0]]) begin
                        found  = 1'b1;
                        winner = cand[PTR_W-1:0];
                    end
                end
                if (found && has_credit) begin
                    transfer = 1'b1;
                    sel      = winner;
                    if (tail[winner]) begin
                        ptr_next = wrap_inc(winner);
                    end else begin
                        state_next = LOCKED;
                        owner_next = winner;
                    end
                end
            end
            LOCKED: begin
                if (req[owner] && head[owner]) begin
                    err_next = 1'b1;
                end else if (req[owner] && has_credit) begin
                    transfer = 1'b1;
                    sel      = owner;
                    if (tail[owner]) begin
                        state_next = IDLE;
                        ptr_next   = wrap_inc(owner);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        transfer = transfer & reset;
        if (transfer) begin
            grant[sel] = 1'b1;
        end

        case ({transfer, credit_in})
            2'b10: credits_next = credits - CNT_W'(1);
            2'b01: begin
                if (credits == CNT_W'(BUF_DEPTH)) begin
                    err_next = 1'b1;
                end else begin
                    credits_next = credits + CNT_W'(1);
                end
            end
            default: credits_next = credits;
        endcase
    end

    // Holds FSM state, round-robin pointer, packet owner, credit count and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            credits <= CNT_W'(BUF_DEPTH);
            err     <= 1'b0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            owner   <= owner_next;
            credits <= credits_next;
            err     <= err_next;
        end
    end

    // Registers the granted flit onto the link; data holds when nothing is sent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_flit  <= '0;
        end else begin
            out_valid <= transfer;
            if (transfer) begin
                out_flit <= flit_array[sel];
            end
        end
    end

endmodule

// File: tb/tb_noc_output_port_arbiter.sv
// Self-checking bench for noc_output_port_arbiter: directed scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_noc_output_port_arbiter;

    localparam int NUM_PORTS = 5;
    localparam int FLIT_W    = 34;
    localparam int BUF_DEPTH = 4;
    localparam int PTR_W     = $clog2(NUM_PORTS);
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

    logic                        clk = 1'b0;
    logic                        reset;
    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        head;
    logic [NUM_PORTS-1:0]        tail;
    logic [NUM_PORTS*FLIT_W-1:0] in_flit;
    logic                        credit_in;
    logic [NUM_PORTS-1:0]        grant;
    logic                        out_valid;
    logic [FLIT_W-1:0]           out_flit;
    logic                        locked;
    logic [PTR_W-1:0]            owner;
    logic [CNT_W-1:0]            credits;
    logic                        err;

    int checks   = 0;
    int failures = 0;

    bit                m_locked;
    int                m_owner;
    int                m_ptr;
    int                m_credits;
    bit                m_err;
    bit                m_valid;
    logic [FLIT_W-1:0] m_flit;
    int                m_gnt;
    logic [FLIT_W-1:0] flits [NUM_PORTS];
    logic [NUM_PORTS-1:0] dut_gnt;

    noc_output_port_arbiter #(
        .NUM_PORTS(NUM_PORTS),
        .FLIT_W   (FLIT_W),
        .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .head     (head),
        .tail     (tail),
        .in_flit  (in_flit),
        .credit_in(credit_in),
        .grant    (grant),
        .out_valid(out_valid),
        .out_flit (out_flit),
        .locked   (locked),
        .owner    (owner),
        .credits  (credits),
        .err      (err)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Guards against a run that never reaches its summary.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_locked  = 1'b0;
        m_owner   = 0;
        m_ptr     = 0;
        m_credits = BUF_DEPTH;
        m_err     = 1'b0;
        m_valid   = 1'b0;
        m_flit    = '0;
    endtask

    task automatic checkRegs();
        checkOutput("locked", 64'(locked), 64'(m_locked));
        if (m_locked) begin
            checkOutput("owner", 64'(owner), 64'(m_owner));
        end
        checkOutput("credits", 64'(credits), 64'(m_credits));
        checkOutput("err", 64'(err), 64'(m_err));
        checkOutput("out_valid", 64'(out_valid), 64'(m_valid));
        checkOutput("out_flit", 64'(out_flit), 64'(m_flit));
    endtask

    // Drives one cycle of inputs, checks the combinational grant, advances the model, checks registers.
    task automatic applyStimulus(input logic [NUM_PORTS-1:0] r, input logic [NUM_PORTS-1:0] h,
                                 input logic [NUM_PORTS-1:0] t, input logic c);
        logic [63:0] rnd;
        logic [63:0] ev;
        int          g;
        int          p;
        bit          eset;
        req       = r;
        head      = h;
        tail      = t;
        credit_in = c;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rnd      = {$urandom(), $urandom()};
            flits[i] = rnd[FLIT_W-1:0];
            in_flit[i*FLIT_W +: FLIT_W] = flits[i];
        end
        #1;
        g    = -1;
        eset = 1'b0;
        if (!m_locked) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (r[i] && !h[i]) eset = 1'b1;
            end
            if (m_credits > 0) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    p = (m_ptr + k) % NUM_PORTS;
                    if (g < 0 && r[p] && h[p]) g = p;
                end
            end
        end else begin
            if (r[m_owner] && h[m_owner]) eset = 1'b1;
            else if (r[m_owner] && m_credits > 0) g = m_owner;
        end
        ev = '0;
        if (g >= 0) ev[g] = 1'b1;
        dut_gnt = grant;
        m_gnt   = g;
        checkOutput("grant", 64'(grant), ev);

        if (g >= 0 && !c) begin
            m_credits--;
        end else if (c && g < 0) begin
            if (m_credits == BUF_DEPTH) eset = 1'b1;
            else m_credits++;
        end
        if (g >= 0) begin
            m_valid = 1'b1;
            m_flit  = flits[g];
            if (!m_locked) begin
                if (t[g]) begin
                    m_ptr = (g + 1) % NUM_PORTS;
                end else begin
                    m_locked = 1'b1;
                    m_owner  = g;
                end
            end else if (t[g]) begin
                m_locked = 1'b0;
                m_ptr    = (g + 1) % NUM_PORTS;
            end
        end else begin
            m_valid = 1'b0;
        end
        m_err = m_err | eset;

        @(posedge clk);
        #1;
        checkRegs();
    endtask

    // Asserts reset asynchronously, checks immediate clearing, holds one edge, then releases.
    task automatic doReset();
        reset     = 1'b0;
        req       = '0;
        head      = '0;
        tail      = '0;
        credit_in = 1'b0;
        #1;
        checkOutput("rst_locked", 64'(locked), 64'(0));
        checkOutput("rst_credits", 64'(credits), 64'(BUF_DEPTH));
        checkOutput("rst_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_grant", 64'(grant), 64'(0));
        modelReset();
        @(posedge clk);
        #1;
        checkRegs();
        reset = 1'b1;
    endtask

    initial begin
        int cnt;
        int plen [NUM_PORTS];
        int pidx [NUM_PORTS];
        logic [NUM_PORTS-1:0] r;
        logic [NUM_PORTS-1:0] h;
        logic [NUM_PORTS-1:0] t;
        logic c;

        in_flit = '0;
        @(negedge clk);
        doReset();

        $display("[TB] round-robin single-flit packets");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(5'b00011, 5'b00011, 5'b00011, 1'b1);
            checkOutput("rr_alt", 64'(dut_gnt), 64'((k % 2) != 0 ? 5'b00010 : 5'b00001));
        end

        $display("[TB] wormhole lock on port 2");
        applyStimulus(5'b00110, 5'b00110, 5'b00000, 1'b1);
        checkOutput("lock_g0", 64'(dut_gnt), 64'(5'b00100));
        checkOutput("lock_owner", 64'(owner), 64'(2));
        applyStimulus(5'b00110, 5'b00010, 5'b00000, 1'b1);
        checkOutput("lock_g1", 64'(dut_gnt), 64'(5'b00100));
        applyStimulus(5'b00110, 5'b00010, 5'b00100, 1'b1);
        checkOutput("lock_g2", 64'(dut_gnt), 64'(5'b00100));
        applyStimulus(5'b00010, 5'b00010, 5'b00010, 1'b1);
        checkOutput("lock_after", 64'(dut_gnt), 64'(5'b00010));

        $display("[TB] credit exhaustion on port 0");
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(5'b00001, (k == 0) ? 5'b00001 : 5'b00000, 5'b00000, 1'b0);
            if (dut_gnt != '0) cnt++;
        end
        checkOutput("exh_grants", 64'(cnt), 64'(4));
        checkOutput("exh_credits", 64'(credits), 64'(0));
        checkOutput("exh_locked", 64'(locked), 64'(1));
        applyStimulus(5'b00001, 5'b00000, 5'b00000, 1'b1);
        if (dut_gnt != '0) cnt++;
        applyStimulus(5'b00001, 5'b00000, 5'b00000, 1'b0);
        if (dut_gnt != '0) cnt++;
        applyStimulus(5'b00001, 5'b00000, 5'b00000, 1'b0);
        if (dut_gnt != '0) cnt++;
        checkOutput("exh_resume", 64'(cnt), 64'(5));
        applyStimulus(5'b00000, 5'b00000, 5'b00000, 1'b1);
        applyStimulus(5'b00001, 5'b00000, 5'b00001, 1'b0);
        checkOutput("exh_tail", 64'(dut_gnt), 64'(5'b00001));

        $display("[TB] simultaneous credit and transfer, saturation");
        applyStimulus(5'b00000, 5'b00000, 5'b00000, 1'b1);
        applyStimulus(5'b00000, 5'b00000, 5'b00000, 1'b1);
        applyStimulus(5'b10000, 5'b10000, 5'b10000, 1'b1);
        checkOutput("both_credits", 64'(credits), 64'(2));
        applyStimulus(5'b00000, 5'b00000, 5'b00000, 1'b1);
        applyStimulus(5'b00000, 5'b00000, 5'b00000, 1'b1);
        checkOutput("sat_pre_err", 64'(err), 64'(0));
        applyStimulus(5'b00000, 5'b00000, 5'b00000, 1'b1);
        checkOutput("sat_credits", 64'(credits), 64'(4));
        checkOutput("sat_err", 64'(err), 64'(1));
        applyStimulus(5'b00000, 5'b00000, 5'b00000, 1'b0);
        checkOutput("err_sticky", 64'(err), 64'(1));
        doReset();

        $display("[TB] reset mid-packet");
        applyStimulus(5'b00010, 5'b00010, 5'b00000, 1'b0);
        applyStimulus(5'b00010, 5'b00000, 5'b00000, 1'b0);
        doReset();
        applyStimulus(5'b01000, 5'b01000, 5'b01000, 1'b0);
        checkOutput("post_rst_g", 64'(dut_gnt), 64'(5'b01000));

        $display("[TB] protocol errors");
        applyStimulus(5'b00001, 5'b00000, 5'b00000, 1'b0);
        checkOutput("body_idle_g", 64'(dut_gnt), 64'(0));
        checkOutput("body_idle_err", 64'(err), 64'(1));
        doReset();
        applyStimulus(5'b00100, 5'b00100, 5'b00000, 1'b0);
        applyStimulus(5'b00100, 5'b00100, 5'b00000, 1'b0);
        checkOutput("owner_head_g", 64'(dut_gnt), 64'(0));
        checkOutput("owner_head_err", 64'(err), 64'(1));
        checkOutput("owner_head_lock", 64'(locked), 64'(1));
        doReset();

        $display("[TB] random well-formed traffic");
        for (int i = 0; i < NUM_PORTS; i++) begin
            plen[i] = $urandom_range(1, 4);
            pidx[i] = 0;
        end
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r[i] = ($urandom_range(0, 3) != 0);
                h[i] = (pidx[i] == 0);
                t[i] = (pidx[i] == plen[i] - 1);
            end
            c = (m_credits < BUF_DEPTH) && ($urandom_range(0, 1) != 0);
            applyStimulus(r, h, t, c);
            if (m_gnt >= 0) begin
                pidx[m_gnt]++;
                if (pidx[m_gnt] == plen[m_gnt]) begin
                    pidx[m_gnt] = 0;
                    plen[m_gnt] = $urandom_range(1, 4);
                end
            end
        end
        checkOutput("wf_no_err", 64'(err), 64'(0));
        doReset();

        $display("[TB] random unconstrained traffic");
        for (int n = 0; n < 1500; n++) begin
            r = NUM_PORTS'($urandom());
            h = NUM_PORTS'($urandom());
            t = NUM_PORTS'($urandom());
            c = ($urandom_range(0, 2) == 0);
            applyStimulus(r, h, t, c);
            if (n % 300 == 299) doReset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_output_port_arbiter.md
Name: noc_output_port_arbiter

Overview:
- Wormhole output-port allocator for one router output (N/E/S/W/Local).
- Shares a single output link among NUM_PORTS input buffers using round-robin priority on head flits.
- Holds the grant for the winning input until that packet's tail flit passes, so packets are never interleaved.
- Tracks downstream buffer space with a credit counter and registers the selected flit onto the link.

Parameters:
- NUM_PORTS, 5, number of requesting input ports (index 0 = Local, 1..4 = N/E/S/W).
- FLIT_W, 34, flit width in bits, including the head and tail marker bits carried by the flit.
- BUF_DEPTH, 4, downstream input-buffer depth; this is the initial and maximum credit count.
- PTR_W, $clog2(NUM_PORTS), width of the priority pointer and of owner.
- CNT_W, $clog2(BUF_DEPTH+1), width of the credit counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  NUM_PORTS  input i has a valid flit at its buffer head.
- head  in  NUM_PORTS  flit at input i is a head flit.
- tail  in  NUM_PORTS  flit at input i is a tail flit (head&tail = single-flit packet).
- in_flit  in  NUM_PORTS*FLIT_W  flattened flits; port i occupies bits [i*FLIT_W +: FLIT_W].
- credit_in  in  1  downstream freed one buffer slot this cycle.
- grant  out  NUM_PORTS  combinational one-hot pop strobe; the flit of input i is consumed this cycle.
- out_valid  out  1  registered, flit valid on the link.
- out_flit  out  FLIT_W  registered flit data.
- locked  out  1  a packet currently owns the output.
- owner  out  PTR_W  index of the owning input; meaningful only while locked.
- credits  out  CNT_W  current credit count.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset values (async, reset=0): state=IDLE, ptr=0, owner=0, locked=0, credits=BUF_DEPTH, out_valid=0, out_flit=0, err=0. A reset mid-packet abandons the packet with no further grants.
- A transfer occurs in a cycle iff grant!=0. A transfer requires credits>0.

State machine:
- IDLE:
  - eligible = req & head.
  - If eligible!=0 and credits>0, grant the first eligible index searching upward from ptr with modular wrap.
  - If the winner's flit is also a tail, stay IDLE and set ptr=winner+1 (mod NUM_PORTS).
  - Otherwise go to LOCKED with owner=winner.
  - Requests with req=1 and head=0 while IDLE produce no grant and set err.
- LOCKED:
  - grant[owner]=1 iff req[owner] and credits>0. All other inputs are blocked.
  - If a granted flit is a tail, go to IDLE and set ptr=owner+1 (mod NUM_PORTS).
  - If req[owner] and head[owner] are both 1, set err, issue no grant, and stay LOCKED.

Link register:
- On a transfer at cycle t, out_valid=1 and out_flit=the granted flit at t+1, so latency is 1 cycle.
- Otherwise out_valid=0 and out_flit holds its value.
- At most one flit is output per cycle.

Credits:
- Transfer only: credits-1. credit_in only: credits+1.
- Both in the same cycle: credits unchanged.
- credit_in while credits==BUF_DEPTH with no transfer: saturate and set err.
- credits==0 blocks all grants; the lock is kept and resumes when a credit returns.

Outputs and errors:
- locked is 1 exactly in LOCKED. owner is registered.
- err clears only on reset.

Test Plan:
- Single-flit packets: req=5'b00011, head=tail=5'b00011, continuous, credits held at 4 by returning credit_in each cycle -> grant alternates 00001, 00010, 00001...; out_flit follows one cycle later.
- Wormhole lock: 3-flit packet on port 2 while port 1 repeatedly requests a head -> grant=00100 for 3 cycles, locked=1 with owner=2, port 1 starved; grant=00010 on the cycle after the tail; ptr=3 after port 2's tail.
- Credit exhaustion: BUF_DEPTH=4, 6-flit packet on port 0, no credit_in -> 4 grants, credits=0, stall with locked=1; one credit_in pulse -> exactly one more grant.
- Simultaneous credit_in and transfer with credits=2 -> credits stays 2. credit_in at credits=4 with no transfer -> credits stays 4 and err=1.
- Reset mid-packet: assert reset=0 after the 2nd of 4 flits -> locked=0, credits=4, out_valid=0 immediately. After release, a new head on port 3 (ptr=0, ports 0..2 idle) is granted.
- Protocol errors: body flit (head=0) request while IDLE -> no grant, err=1. Head flit from the owner while LOCKED -> no grant, err=1.
